fetch_tcm_responder: RTL and testbench
======================================

// Module: fetch_tcm_responder
// PURPOSE
//  Responder for the core's 64-bit instruction-fetch interface (mem_i_*).
//  Accepts fetch requests from riscv_core, reads a synchronous 64-bit TCM
//  SRAM port, and returns in-order responses after a fixed latency.
//  Flushed requests return nothing. An LFSR can inject accept stalls for
//  stress testing. Sits between u_dut and the TCM RAM in the bench and SoC.
// PARAMETERS
//  MEM_BASE    32'h80000000  byte address of TCM word 0
//  MEM_WORDS   16384         number of 64-bit words (128KB); power of 2
//  LATENCY     2             accept-to-valid cycles, range 1..4
//  STALL_EN    0             1 = LFSR-driven accept stalls enabled
//  LFSR_SEED   16'hACE1      non-zero reset value of the 16-bit stall LFSR
// PORTS
//  clk_i               in   1   clock, all logic on rising edge
//  rst_i               in   1   asynchronous, active-low reset
//  mem_i_rd_i          in   1   fetch request valid
//  mem_i_flush_i       in   1   discard all in-flight fetches
//  mem_i_invalidate_i  in   1   cache invalidate; no-op (no cache here)
//  mem_i_pc_i          in   32  fetch byte address
//  mem_i_accept_o      out  1   request accepted this cycle
//  mem_i_valid_o       out  1   response valid (1-cycle pulse per response)
//  mem_i_error_o       out  1   response is a bus error (qualified by valid)
//  mem_i_inst_o        out  64  fetched instruction pair
//  ram_rd_o            out  1   SRAM read strobe
//  ram_addr_o          out  log2(MEM_WORDS)  SRAM 64-bit word index
//  ram_data_i          in   64  SRAM read data, valid 1 cycle after ram_rd_o
// BEHAVIOUR
//  - Reset: accept=0, valid=0, error=0, inst=0, ram_rd=0, ram_addr=0,
//    pipeline valid bits cleared, LFSR=LFSR_SEED. Asserting reset mid-run
//    drops all in-flight requests; no response after reset release.
//  - accept_o = !mem_i_flush_i & (STALL_EN ? !lfsr[0] : 1). It is a
//    combinational grant; a request is taken when rd_i & accept_o.
//  - LFSR: x^16+x^14+x^13+x^11, advances every cycle out of reset.
//  - Accepted request: off = pc - MEM_BASE. error if off >= MEM_WORDS*8 or
//    pc[1:0]!=0. Otherwise ram_rd_o=1, ram_addr_o=off[3 +: log2(MEM_WORDS)]
//    in the same cycle (pc[2] ignored: 64-bit aligned fetch). Errored
//    requests do not strobe the RAM.
//  - Pipeline: LATENCY-stage shift register of {valid, error}. Stage 1
//    captures ram_data_i; later stages carry data forward. Exactly one
//    response per accepted request, in order, LATENCY cycles after accept.
//    Throughput 1 request/cycle; no response backpressure.
//  - Error response: valid=1, error=1, inst=0.
//  - Non-valid cycles: valid=0, error=0; inst holds last value.
//  - Flush: in the flush cycle accept_o=0 and every stage valid bit clears
//    on the next edge; no response ever appears for requests accepted
//    before or during the flush cycle. A request in the cycle after flush
//    is accepted normally.
//  - invalidate_i has no effect on any state or output.
// TESTING
//  1. Reset, rd=1 pc=80000000, ram word0=0x00B0059300700513 -> accept same
//     cycle; valid=1 error=0 inst=0x00B0059300700513 exactly 2 cycles later.
//  2. Back-to-back pc=80000000,80000008,80000010 -> 3 consecutive valid
//     pulses, in order, ram_addr 0,1,2; pc=80000004 returns word 0.
//  3. pc=8001FFF8 -> valid, ram_addr=16383; pc=80020000 and pc=7FFFFFF8 and
//     pc=80000002 -> valid=1 error=1 inst=0, ram_rd_o never asserted.
//  4. Issue 2 requests, flush in cycle after the 2nd -> no valid pulse for
//     either; request 1 cycle after flush returns 2 cycles later.
//  5. Reset low while 2 requests in flight -> all outputs 0 immediately;
//     no valid after release. LATENCY=1 and 4 builds repeat scenario 2.
//  6. STALL_EN=1, 1000 random requests vs scoreboard -> responses ==
//     accepted count, all in order, accept_o low exactly when lfsr[0]=1.

Source files
------------

// File: rtl/fetch_tcm_responder_if.sv
// Instruction-fetch bus (core side) plus synchronous TCM read port (RAM side)
// seen by fetch_tcm_responder.
interface fetch_tcm_responder_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              mem_i_rd_i;
    logic              mem_i_flush_i;
    logic              mem_i_invalidate_i;
    logic [31:0]       mem_i_pc_i;
    logic              mem_i_accept_o;
    logic              mem_i_valid_o;
    logic              mem_i_error_o;
    logic [63:0]       mem_i_inst_o;
    logic              ram_rd_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [63:0]       ram_data_i;

    modport slave (
        input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i, ram_data_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
               ram_rd_o, ram_addr_o
    );

    modport master (
        output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i, ram_data_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
               ram_rd_o, ram_addr_o
    );
endinterface

// File: rtl/fetch_tcm_responder.sv
// Fixed-latency, in-order instruction-fetch responder in front of a 64-bit TCM,
// with flush support and optional LFSR-driven accept stalls.
module fetch_tcm_responder #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fetch_tcm_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned DW = 64;

    logic [15:0]      lfsr_q;
    logic [LATENCY:1] vld_q;
    logic [LATENCY:1] err_q;
    logic [DW-1:0]    dat_q   [LATENCY:1];
    logic [DW-1:0]    stg_dat [LATENCY:1];
    logic [31:0]      off;
    logic             bad;
    logic             flush;
    logic             take_c;
    logic             out_vld;
    logic             unused_bits;

    // Address decode: out of window or not 32-bit aligned is a bus error
    assign off   = bus.mem_i_pc_i - MEM_BASE;
    assign bad   = (|off[31:AW+3]) | (|bus.mem_i_pc_i[1:0]);
    assign flush = bus.mem_i_flush_i;

    assign bus.mem_i_accept_o = rst_i & ~flush & ((STALL_EN != 0) ? ~lfsr_q[0] : 1'b1);
    assign take_c             = bus.mem_i_rd_i & bus.mem_i_accept_o;
    assign bus.ram_rd_o       = take_c & ~bad;
    assign bus.ram_addr_o     = rst_i ? off[AW+2:3] : '0;

    // pc[2] selects nothing: the whole 64-bit pair is returned
    assign unused_bits = ^{off[2:0], bus.mem_i_invalidate_i};

    // Stall LFSR, x^16+x^14+x^13+x^11
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Stage 1 data is the RAM output itself; later stages are registered copies
    always_comb begin
        stg_dat[1] = err_q[1] ? '0 : bus.ram_data_i;
        for (int k = 2; k <= int'(LATENCY); k++) begin
            stg_dat[k] = dat_q[k-1];
        end
    end

    assign out_vld = vld_q[LATENCY] & ~flush;

    // dat_q[LATENCY] doubles as the hold register for inst between responses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 1; k <= int'(LATENCY); k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[1] <= take_c;
            err_q[1] <= take_c & bad;
            for (int k = 2; k <= int'(LATENCY); k++) begin
                vld_q[k] <= vld_q[k-1] & ~flush;
                err_q[k] <= err_q[k-1];
            end
            for (int k = 1; k < int'(LATENCY); k++) begin
                if (vld_q[k] & ~flush) dat_q[k] <= stg_dat[k];
            end
            if (out_vld) dat_q[LATENCY] <= stg_dat[LATENCY];
        end
    end

    assign bus.mem_i_valid_o = out_vld;
    assign bus.mem_i_error_o = out_vld & err_q[LATENCY];
    assign bus.mem_i_inst_o  = out_vld ? stg_dat[LATENCY] : dat_q[LATENCY];

endmodule

// File: tb/tb_fetch_tcm_responder.sv
// Randomised bench for fetch_tcm_responder: four builds (latency 2/1/4 and a
// stalling latency-3 build) share one stimulus stream, each checked against a scoreboard.
module tb_fetch_tcm_responder;
    localparam int NDUT = 4;
    localparam int unsigned LAT [NDUT] = '{2, 1, 4, 3};
    localparam int unsigned STL [NDUT] = '{0, 0, 0, 1};
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [63:0] WORD0 = 64'h00B0_0593_0070_0513;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, flush, inv;
    logic [31:0] pc;

    logic        acc   [NDUT];
    logic        vld   [NDUT];
    logic        err   [NDUT];
    logic [63:0] inst  [NDUT];
    logic        rrd   [NDUT];
    logic [13:0] raddr [NDUT];
    logic [63:0] rdata [NDUT];
    logic [63:0] mem   [16384];

    typedef struct {
        int          dut;
        int          due;
        logic        err;
        logic [63:0] data;
    } resp_t;

    resp_t       sb [$];
    logic [15:0] lfsr_m  [NDUT];
    logic [63:0] last_m  [NDUT];
    int          exp_cnt [NDUT];
    int          seen    [NDUT];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fetch_tcm_responder_if #(.ADDR_W(14)) bus ();

        fetch_tcm_responder #(
            .LATENCY  (LAT[g]),
            .STALL_EN (STL[g])
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst_n),
            .bus   (bus)
        );

        assign bus.mem_i_rd_i         = rd;
        assign bus.mem_i_flush_i      = flush;
        assign bus.mem_i_invalidate_i = inv;
        assign bus.mem_i_pc_i         = pc;
        assign bus.ram_data_i         = rdata[g];
        assign acc[g]   = bus.mem_i_accept_o;
        assign vld[g]   = bus.mem_i_valid_o;
        assign err[g]   = bus.mem_i_error_o;
        assign inst[g]  = bus.mem_i_inst_o;
        assign rrd[g]   = bus.ram_rd_o;
        assign raddr[g] = bus.ram_addr_o;

        // Synchronous TCM model: data one cycle after the read strobe
        always @(posedge clk) begin
            if (rrd[g]) rdata[g] <= mem[raddr[g]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drop(input int k);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].dut == k) sb.delete(i);
        end
    endtask

    // Reference: each accepted fetch becomes a scoreboard entry due LAT cycles later
    task automatic model_step(input int k);
        logic        exp_acc, take, bad, ev, ee;
        logic [63:0] ed;
        logic [31:0] off;
        int          idx;
        if (!rst_n) begin
            lfsr_m[k] = SEED;
            last_m[k] = '0;
            drop(k);
        end
        exp_acc = rst_n && !flush && !(STL[k] != 0 && lfsr_m[k][0]);
        check($sformatf("accept[%0d]", k), 64'(acc[k]), 64'(exp_acc));
        off  = pc - 32'h8000_0000;
        bad  = (off >= 32'd131072) || (pc[1:0] != 2'b00);
        take = rd && exp_acc;
        check($sformatf("ram_rd[%0d]", k), 64'(rrd[k]), 64'(take && !bad));
        if (take && !bad) check($sformatf("ram_addr[%0d]", k), 64'(raddr[k]), 64'(off / 8));
        if (!rst_n) check($sformatf("ram_addr_rst[%0d]", k), 64'(raddr[k]), 64'd0);

        ev = 1'b0;
        ee = 1'b0;
        ed = last_m[k];
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].dut == k && sb[i].due == cyc) idx = i;
        end
        if (idx >= 0) begin
            if (rst_n && !flush) begin
                ev = 1'b1;
                ee = sb[idx].err;
                ed = sb[idx].data;
                last_m[k] = ed;
                exp_cnt[k]++;
            end
            sb.delete(idx);
        end
        check($sformatf("valid[%0d]", k), 64'(vld[k]), 64'(ev));
        check($sformatf("error[%0d]", k), 64'(err[k]), 64'(ee));
        check($sformatf("inst[%0d]", k), inst[k], ed);
        if (vld[k]) seen[k]++;

        if (flush) drop(k);
        if (take) sb.push_back('{k, cyc + int'(LAT[k]), bad, bad ? 64'd0 : mem[off / 8]});
        if (rst_n) lfsr_m[k] = {^(lfsr_m[k] & 16'h002D), lfsr_m[k][15:1]};
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) model_step(k);
        cyc++;
    end

    task automatic drive(input logic r, input logic [31:0] p, input logic f);
        @(posedge clk);
        #1;
        rd    = r;
        pc    = p;
        flush = f;
        inv   = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h8000_0000, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return 32'h8002_0000 + ($urandom_range(0, 255) * 8);
            1:       return 32'h8000_0000 - ($urandom_range(1, 64) * 8);
            2:       return 32'h8000_0000 + ($urandom_range(0, 16383) * 8) + 32'($urandom_range(1, 3));
            3:       return 32'h8001_FFF8 - ($urandom_range(0, 3) * 8);
            default: return 32'h8000_0000 + ($urandom_range(0, 16383) * 8) + (($urandom_range(0, 1)) * 4);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        rd    = 1'b0;
        flush = 1'b0;
        inv   = 1'b0;
        pc    = 32'h0;
        for (int k = 0; k < NDUT; k++) begin
            lfsr_m[k]  = SEED;
            last_m[k]  = '0;
            exp_cnt[k] = 0;
            seen[k]    = 0;
        end
        for (int i = 0; i < 16384; i++) mem[i] = {$urandom, $urandom};
        mem[0] = WORD0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(vld[0]), 64'd0);
        check("rst_inst", inst[0], 64'd0);
        check("rst_accept", 64'(acc[0]), 64'd0);
        check("rst_ram_rd", 64'(rrd[0]), 64'd0);
        rst_n = 1'b1;

        // Single fetch of word 0, response two cycles after accept
        drive(1'b1, 32'h8000_0000, 1'b0);
        #1 check("t1_accept", 64'(acc[0]), 64'd1);
        idle(2);
        @(negedge clk);
        check("t1_valid", 64'(vld[0]), 64'd1);
        check("t1_error", 64'(err[0]), 64'd0);
        check("t1_inst", inst[0], WORD0);

        // Back-to-back, including the pc[2]=1 alias of word 0
        drive(1'b1, 32'h8000_0000, 1'b0);
        drive(1'b1, 32'h8000_0008, 1'b0);
        drive(1'b1, 32'h8000_0010, 1'b0);
        #1 check("t2_addr2", 64'(raddr[0]), 64'd2);
        drive(1'b1, 32'h8000_0004, 1'b0);
        #1 check("t2_alias_addr", 64'(raddr[0]), 64'd0);
        idle(5);

        // Window edges and misalignment
        drive(1'b1, 32'h8001_FFF8, 1'b0);
        #1 check("t3_top_addr", 64'(raddr[0]), 64'd16383);
        drive(1'b1, 32'h8002_0000, 1'b0);
        drive(1'b1, 32'h7FFF_FFF8, 1'b0);
        drive(1'b1, 32'h8000_0002, 1'b0);
        #1 check("t3_misalign_rd", 64'(rrd[0]), 64'd0);
        idle(5);

        // Flush the cycle after the second request, then fetch again
        drive(1'b1, 32'h8000_0020, 1'b0);
        drive(1'b1, 32'h8000_0028, 1'b0);
        drive(1'b0, 32'h8000_0000, 1'b1);
        drive(1'b1, 32'h8000_0030, 1'b0);
        idle(6);

        // Reset while requests are in flight
        drive(1'b1, 32'h8000_0040, 1'b0);
        drive(1'b1, 32'h8000_0048, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd    = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("t5_valid[%0d]", k), 64'(vld[k]), 64'd0);
            check($sformatf("t5_inst[%0d]", k), inst[k], 64'd0);
            check($sformatf("t5_accept[%0d]", k), 64'(acc[k]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        drive(1'b1, 32'h8000_0000, 1'b0);
        drive(1'b1, 32'h8000_0008, 1'b0);
        drive(1'b1, 32'h8000_0010, 1'b0);
        idle(6);

        // Random traffic with occasional flushes
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), rand_pc(), 1'($urandom_range(0, 49) == 0));
        end
        idle(8);
        @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("resp_count[%0d]", k), 64'(seen[k]), 64'(exp_cnt[k]));
        end
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
